alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's combinational 8-op ALU. It accepts one operation per transaction over a valid/ready input channel and returns the result plus status flags over a valid/ready output channel. Add, subtract and logic ops complete in one cycle. Multiplies run on an iterative shift-add engine, and both low and high product halves are now available. It sits between the datapath operand registers and the writeback stage.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_mul_iter.sv | 58 +++++
 rtl/alu_seq.sv | 126 ++++++++++++
 tb/tb_alu_seq.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the handshaked sequential ALU.
//   op_e    - operation encodings (3 bits)
//   state_e - control FSM states
//   is_mul  - true for the two multiply ops, which go through the iterative engine
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_INC  = 3'b001,
        OP_SUB  = 3'b010,
        OP_DEC  = 3'b011,
        OP_MULL = 3'b100,
        OP_MULH = 3'b101,
        OP_AND  = 3'b110,
        OP_XOR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_mul(op_e op);
        return (op == OP_MULL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response channels of alu_seq.
//   request : in_valid, in_ready, op, a, b
//   response: out_valid, out_ready, result, flag_z, flag_c, flag_v
//   master = requester/consumer side, slave = the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_c, flag_v
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_z, flag_c, flag_v
    );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands and begin a WIDTH-step run
//   a, b       : multiplicand, multiplier
//   busy       : a run is in progress (counter nonzero)
//   done       : the step taking place this cycle is the last one
//   product    : accumulator value after the current step; equals a*b
//                in the cycle done is high
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplr;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     upper_sum;

    // Add into the upper half, then shift the whole accumulator right; the
    // add's carry becomes the new MSB so no product bit is lost.
    always_comb begin
        upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplr[0] ? {1'b0, mcand} : '0);
        acc_next  = {upper_sum, acc[WIDTH-1:1]};
    end

    assign busy    = (cnt != '0);
    assign done    = (cnt == CW'(1));
    assign product = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mplr  <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else if (start) begin
            acc   <= '0;
            mplr  <= b;
            mcand <= a;
            cnt   <= CW'(WIDTH);
        end else if (busy) begin
            acc   <= acc_next;
            mplr  <= mplr >> 1;
            cnt   <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked 8-op ALU with an iterative multiplier.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_seq_if slave - request (in_valid/in_ready/op/a/b) and
//                response (out_valid/out_ready/result/flag_z/c/v)
// One transaction at a time: IDLE accepts, MUL iterates, DONE presents the
// result until the consumer takes it.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    state_e             state;
    op_e                op_q;
    op_e                op_in;
    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_sel;

    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    assign op_in = op_e'(bus.op);
    // The engine is always idle in IDLE; the busy term only guarantees a
    // start can never restart a run in progress.
    assign accept    = (state == IDLE) && bus.in_valid && !mul_busy;
    assign mul_start = accept && is_mul(op_in);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign mul_sel = (op_q == OP_MULH) ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

    // Single-cycle ops. Carry/borrow is bit WIDTH of the widened add/sub.
    always_comb begin
        opnd    = ((op_in == OP_INC) || (op_in == OP_DEC)) ? WIDTH'(1) : bus.b;
        ext     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_in)
            OP_ADD, OP_INC: begin
                ext     = {1'b0, bus.a} + {1'b0, opnd};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == opnd[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                ext     = {1'b0, bus.a} - {1'b0, opnd};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != opnd[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_q          <= OP_ADD;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.flag_z    <= 1'b0;
            bus.flag_c    <= 1'b0;
            bus.flag_v    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q         <= op_in;
                        bus.in_ready <= 1'b0;
                        if (is_mul(op_in)) begin
                            state <= MUL;
                        end else begin
                            bus.result    <= alu_res;
                            bus.flag_z    <= (alu_res == '0);
                            bus.flag_c    <= alu_c;
                            bus.flag_v    <= alu_v;
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        bus.result    <= mul_sel;
                        bus.flag_z    <= (mul_sel == '0);
                        bus.flag_c    <= (op_q == OP_MULL) && (mul_prod[2*WIDTH-1:WIDTH] != '0);
                        bus.flag_v    <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=32). Expected
// {result,z,c,v} is pushed when a request is driven and popped when the
// result appears.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int            n_pass  = 0;
    int            n_total = 0;
    logic [W+2:0]  sb[$];

    // Reference model: 64-bit arithmetic, signed overflow detected by
    // comparing the exact signed result with the wrapped one.
    function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] o, r;
        logic         c, v;
        logic [63:0]  p;
        longint       s;
        o = (op == 3'd1 || op == 3'd3) ? 32'd1 : b;
        r = '0; c = 1'b0; v = 1'b0;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            3'd0, 3'd1: begin
                r = a + o;
                c = (64'(a) + 64'(o)) > 64'hFFFF_FFFF;
                s = longint'($signed(a)) + longint'($signed(o));
                v = (s != longint'($signed(r)));
            end
            3'd2, 3'd3: begin
                r = a - o;
                c = (a < o);
                s = longint'($signed(a)) - longint'($signed(o));
                v = (s != longint'($signed(r)));
            end
            3'd4: begin r = p[31:0]; c = (p[63:32] != 32'd0); end
            3'd5: r = p[63:32];
            3'd6: r = a & b;
            default: r = a ^ b;
        endcase
        return {r, (r == 32'd0), c, v};
    endfunction

    function automatic logic [W+2:0] obs();
        return {bus.result, bus.flag_z, bus.flag_c, bus.flag_v};
    endfunction

    // Drive one request; returns #1 after the accept edge with operands scrambled.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        while (!bus.in_ready && t < 200) begin @(posedge clk); #1; t++; end
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
    endtask

    // Edges from the accept edge to the first edge seeing out_valid; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = 3'd0; bus.a = '0; bus.b = '0;
        rst_n = 1'b0;
        #12;
        n_total++;
        if ({bus.in_ready, bus.out_valid, obs()} !== {1'b1, 1'b0, 35'd0})
            $display("FAIL reset_state got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=0", bus.in_ready, bus.out_valid, obs());
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL reset_release got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_alu_ops();
        int lat;
        logic [W+2:0] exp;
        for (int i = 0; i < 4; i++) begin
            send(3'(i), 32'h86, 32'h78);
            wait_out(lat);
            n_total++;
            if (lat !== 1) $display("FAIL alu_latency op=%0d got %0d want 1", i, lat);
            else n_pass++;
            exp = sb.pop_front();
            n_total++;
            if (obs() !== exp) $display("FAIL alu_result op=%0d got %h want %h", i, obs(), exp);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01)
                $display("FAIL alu_handoff op=%0d got vld=%b rdy=%b want vld=0 rdy=1", i, bus.out_valid, bus.in_ready);
            else n_pass++;
        end
    endtask

    task automatic test_mul();
        logic [2:0]   ops[4] = '{3'd4, 3'd5, 3'd4, 3'd5};
        logic [W-1:0] av[4]  = '{32'h86, 32'h86, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] bv[4]  = '{32'h78, 32'h78, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int lat;
        logic [W+2:0] exp;
        for (int i = 0; i < 4; i++) begin
            send(ops[i], av[i], bv[i]);
            wait_out(lat);
            n_total++;
            if (lat !== W + 1) $display("FAIL mul_latency case=%0d got %0d want %0d", i, lat, W + 1);
            else n_pass++;
            exp = sb.pop_front();
            n_total++;
            if (obs() !== exp) $display("FAIL mul_result case=%0d got %h want %h", i, obs(), exp);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01)
                $display("FAIL mul_handoff case=%0d got vld=%b rdy=%b want vld=0 rdy=1", i, bus.out_valid, bus.in_ready);
            else n_pass++;
        end
    endtask

    task automatic test_flags();
        logic [2:0]   ops[3] = '{3'd0, 3'd2, 3'd7};
        logic [W-1:0] av[3]  = '{32'h7FFF_FFFF, 32'h0, 32'h55};
        logic [W-1:0] bv[3]  = '{32'h1, 32'h1, 32'h55};
        int lat;
        logic [W+2:0] exp;
        for (int i = 0; i < 3; i++) begin
            send(ops[i], av[i], bv[i]);
            wait_out(lat);
            n_total++;
            if (lat !== 1) $display("FAIL flag_latency case=%0d got %0d want 1", i, lat);
            else n_pass++;
            exp = sb.pop_front();
            n_total++;
            if (obs() !== exp) $display("FAIL flag_result case=%0d got %h want %h", i, obs(), exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [2:0] op;
        logic [W+2:0] exp;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7));
            send(op, $urandom, (i == 0) ? 32'hFFFF_FFFF : $urandom);
            wait_out(lat);
            n_total++;
            if (lat !== ((op == 3'd4 || op == 3'd5) ? W + 1 : 1))
                $display("FAIL b2b_latency i=%0d op=%0d got %0d", i, op, lat);
            else n_pass++;
            exp = sb.pop_front();
            n_total++;
            if (obs() !== exp) $display("FAIL b2b_result i=%0d op=%0d got %h want %h", i, op, obs(), exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W+2:0] exp;
        bus.out_ready = 1'b0;
        send(3'd0, 32'h1234_5678, 32'h1111_1111);
        wait_out(lat);
        n_total++;
        if (lat !== 1) $display("FAIL bp_latency got %0d want 1", lat);
        else n_pass++;
        exp = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if ({bus.out_valid, bus.in_ready, obs()} !== {1'b1, 1'b0, exp})
                $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b out=%h want vld=1 rdy=0 out=%h",
                         i, bus.out_valid, bus.in_ready, obs(), exp);
            else n_pass++;
            bus.in_valid = (i % 2 == 0); bus.op = 3'd7; bus.a = $urandom; bus.b = $urandom;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_total++;
        if (obs() !== exp) $display("FAIL bp_final got %h want %h", obs(), exp);
        else n_pass++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL bp_transfer got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL bp_no_ghost got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        logic [W+2:0] exp;
        bus.out_ready = 1'b1;
        send(3'd4, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.in_ready, bus.out_valid, obs()} !== {1'b1, 1'b0, 35'd0})
            $display("FAIL mid_mul_reset got rdy=%b vld=%b out=%h want rdy=1 vld=0 out=0", bus.in_ready, bus.out_valid, obs());
        else n_pass++;
        exp = sb.pop_front();  // the interrupted multiply never completes
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(3'd0, 32'h1000_0001, 32'h2000_0002);
        wait_out(lat);
        n_total++;
        if (lat !== 1) $display("FAIL post_reset_latency got %0d want 1", lat);
        else n_pass++;
        exp = sb.pop_front();
        n_total++;
        if (obs() !== exp) $display("FAIL post_reset_add got %h want %h", obs(), exp);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mul();
        test_flags();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end
endmodule
